// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the cache-to-memory responder.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: FSM state enum, byte-lane word type (lane0 = MSB byte), latency limits.
package data_mem_pkg;

  localparam int LANES   = 4;
  localparam int BYTE_W  = 8;
  localparam int WORD_W  = LANES * BYTE_W;

  // Legal latency range and the counter width that covers it.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Lane 0 is the leftmost (most significant) byte and maps to address+0,
  // so a packed 32'hDEADBEEF places 8'hDE on lane 0.
  typedef logic [0:LANES-1][BYTE_W-1:0] lanes_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// mem_word_array: single-port word RAM, synchronous write, registered read.
// Latency: write lands on the clock edge; read data appears one edge after the address.
// Backpressure: none; one access per cycle, read-first when reading and writing the same word.
// Ports: clk; we (write strobe); addr (word index); wdata (write word); rdata (registered read word).
module mem_word_array #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Storage is intentionally not reset: contents survive a reset of the responder.
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder, one word read or write per request from the cache.
// Latency: req accepted at edge N -> mem_done pulses in the cycle after edge N+READ/WRITE_LATENCY.
// Backpressure: busy high from accept through the mem_done cycle; req while busy is dropped, not queued.
// Ports: clk, reset (async, active-low); req/write_en/address/mem_data_in request side;
//        mem_data_out (last read word), mem_done (completion pulse), busy;
//        addr_err (misaligned completion pulse) exists only when MEM_ALIGN_CHECK_EN is defined.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int MEM_BYTES     = 65536,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write_en,
  input  logic [31:0] address,
  input  lanes_t      mem_data_in,
  output lanes_t      mem_data_out,
  output logic        mem_done,
  output logic        busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int WORDS = MEM_BYTES / LANES;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] IDX_MASK = 32'(WORDS - 1);

  // Elaboration-time parameter legality.
  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_rd_lat
    $error("data_mem_responder: READ_LATENCY out of range 1..15");
  end
  if (WRITE_LATENCY < LAT_MIN || WRITE_LATENCY > LAT_MAX) begin : g_bad_wr_lat
    $error("data_mem_responder: WRITE_LATENCY out of range 1..15");
  end
  if (MEM_BYTES < LANES || !is_pow2(MEM_BYTES)) begin : g_bad_size
    $error("data_mem_responder: MEM_BYTES must be a power of two >= 4");
  end

  // Upper address bits drop out here, so accesses wrap modulo MEM_BYTES.
  logic [IDX_W-1:0] in_idx;
  assign in_idx = IDX_W'((address >> 2) & IDX_MASK);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  lanes_t           wdat_q, wdat_d;
  lanes_t           dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic             mis_q, mis_d;
  logic             err_q, err_d;
`endif

  logic             commit_ok;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata;

`ifdef MEM_ALIGN_CHECK_EN
  assign commit_ok = !mis_q;
`else
  assign commit_ok = 1'b1;
`endif

  mem_word_array #(
    .DEPTH (WORDS),
    .AW    (IDX_W),
    .DW    (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ram_we   = 1'b0;
    // The RAM read is registered, so during ACCESS it keeps re-reading the
    // latched word; in IDLE it reads the incoming address so that even a
    // one-edge latency has valid read data at the commit edge.
    ram_addr = idx_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d    = mis_q;
    err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        ram_addr = in_idx;
        if (req) begin
          idx_d   = in_idx;
          we_d    = write_en;
          wdat_d  = mem_data_in;
          cnt_d   = write_en ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
          busy_d  = 1'b1;
          state_d = ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          mis_d   = (address[1:0] != 2'b00);
`endif
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          // Commit edge: the whole word is written or loaded in one edge.
          if (commit_ok) begin
            if (we_q) begin
              ram_we = 1'b1;
            end else begin
              dout_d = lanes_t'(ram_rdata);
            end
          end
          done_d  = 1'b1;
          state_d = DONE;
`ifdef MEM_ALIGN_CHECK_EN
          err_d   = mis_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_data_out = dout_q;
  assign mem_done     = done_q;
  assign busy         = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err     = err_q;
`endif

endmodule
